// File: rtl/mem_pkg.sv
// Shared memory-stage definitions used by the load/store unit and the data cache.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int WORD_BYTES     = 8;
  localparam int LOG_WORD_BYTES = 3;

  // An access is misaligned when any address bit below its size is set.
  function automatic logic is_misaligned(input logic [LOG_WORD_BYTES-1:0] addr_lo,
                                         input logic [1:0] size);
    logic [LOG_WORD_BYTES-1:0] mask;
    case (size)
      SZ_B:    mask = 3'b000;
      SZ_H:    mask = 3'b001;
      SZ_W:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return (addr_lo & mask) != '0;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed field from a 64-bit cache word and sign/zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [63:0]               rdata,
  input  logic [LOG_WORD_BYTES-1:0] addr_lo,
  input  logic [1:0]                size,
  input  logic                      is_unsigned,
  output logic [63:0]               result
);

  logic [63:0] shifted;
  logic        sx;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    sx      = 1'b0;
    result  = shifted;
    case (size)
      SZ_B: begin
        sx     = ~is_unsigned & shifted[7];
        result = {{56{sx}}, shifted[7:0]};
      end
      SZ_H: begin
        sx     = ~is_unsigned & shifted[15];
        result = {{48{sx}}, shifted[15:0]};
      end
      SZ_W: begin
        sx     = ~is_unsigned & shifted[31];
        result = {{32{sx}}, shifted[31:0]};
      end
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: accepts one op, checks alignment, drives the data cache, returns the result.
//   state  | meaning
//   IDLE   | waiting for a request (req_ready=1)
//   ACCESS | request held on the cache interface until hit / write commit
//   RESP   | response presented to writeback until resp_ready
module mem_lsu
  import mem_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic             req_store,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_misaligned,
  output logic [63:0]      dc_addr,
  output logic [63:0]      dc_wdata,
  output logic [1:0]       dc_wlen,
  output logic             dc_enable,
  output logic             dc_wrn,
  input  logic [63:0]      dc_rdata,
  input  logic             dc_valid,
  input  logic             dc_write_done,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] stall_cycles
);

  lsu_state_t       state_q, state_d;
  logic [63:0]      addr_q, wdata_q, resp_data_q, load_result;
  logic [1:0]       size_q;
  logic             uns_q, store_q, mis_q;
  logic [TAG_W-1:0] tag_q;
  logic             req_mis, accept, resp_hs, complete;

  assign req_mis  = is_misaligned(req_addr[LOG_WORD_BYTES-1:0], req_size);
  assign complete = store_q ? dc_write_done : dc_valid;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_mis ? RESP : ACCESS;
      end
      ACCESS: if (complete) state_d = RESP;
      RESP: begin
        req_ready = resp_ready;
        if (resp_ready) state_d = req_valid ? (req_mis ? RESP : ACCESS) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign accept  = req_valid & req_ready;
  assign resp_hs = (state_q == RESP) & resp_ready;

  load_align u_load_align (
    .rdata       (dc_rdata),
    .addr_lo     (addr_q[LOG_WORD_BYTES-1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (load_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      store_q      <= 1'b0;
      tag_q        <= '0;
      mis_q        <= 1'b0;
      resp_data_q  <= '0;
      load_count   <= '0;
      store_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (accept) begin
        addr_q      <= req_addr;
        wdata_q     <= req_wdata;
        size_q      <= req_size;
        uns_q       <= req_unsigned;
        store_q     <= req_store;
        tag_q       <= req_tag;
        mis_q       <= req_mis;
        resp_data_q <= '0;
      end
      if (state_q == ACCESS) begin
        if (complete) resp_data_q <= store_q ? '0 : load_result;
        else if (stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      end
      // Faulted ops never reached the cache, so they are not counted as traffic.
      if (resp_hs && !mis_q) begin
        if (store_q) begin
          if (store_count != '1) store_count <= store_count + 1'b1;
        end else if (load_count != '1) begin
          load_count <= load_count + 1'b1;
        end
      end
    end
  end

  assign dc_enable       = (state_q == ACCESS);
  assign dc_addr         = addr_q;
  assign dc_wdata        = wdata_q;
  assign dc_wlen         = size_q;
  assign dc_wrn          = store_q;
  assign resp_valid      = (state_q == RESP);
  assign resp_data       = resp_data_q;
  assign resp_tag        = tag_q;
  assign resp_misaligned = mis_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu.
module tb_mem_lsu;

  localparam int TAG_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [63:0]      req_addr, req_wdata;
  logic [1:0]       req_size;
  logic             req_unsigned, req_store;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid, resp_ready;
  logic [63:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_misaligned;
  logic [63:0]      dc_addr, dc_wdata, dc_rdata;
  logic [1:0]       dc_wlen;
  logic             dc_enable, dc_wrn, dc_valid, dc_write_done;
  logic [CNT_W-1:0] load_count, store_count, stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_lsu #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_store(req_store), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_misaligned(resp_misaligned),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wlen(dc_wlen),
    .dc_enable(dc_enable), .dc_wrn(dc_wrn), .dc_rdata(dc_rdata),
    .dc_valid(dc_valid), .dc_write_done(dc_write_done),
    .load_count(load_count), .store_count(store_count), .stall_cycles(stall_cycles)
  );

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [63:0] a, input logic [63:0] wd, input logic [1:0] sz,
                           input logic uns, input logic st, input logic [TAG_W-1:0] tg);
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_size = sz;
    req_unsigned = uns; req_store = st; req_tag = tg;
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (dc_enable !== 1'b0) begin bad++; $display("FAIL reset_dc_enable got=%b exp=0", dc_enable); end
    total++; if ({load_count, store_count, stall_cycles} !== '0) begin bad++;
      $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", load_count, store_count, stall_cycles); end
    total++; if (resp_data !== 64'd0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
  endtask

  task automatic test_load_byte();
    drive_req(64'h1003, 64'd0, 2'd0, 1'b0, 1'b0, 5'd5);
    step();
    req_valid = 1'b0;
    total++; if (dc_enable !== 1'b1 || resp_valid !== 1'b0) begin bad++;
      $display("FAIL lb_access dc_enable=%b resp_valid=%b exp=1/0", dc_enable, resp_valid); end
    total++; if (dc_addr !== 64'h1003 || dc_wrn !== 1'b0) begin bad++;
      $display("FAIL lb_dc_addr got=%h wrn=%b exp=1003/0", dc_addr, dc_wrn); end
    dc_rdata = 64'h0000_0000_8000_0000;
    dc_valid = 1'b1;
    step();
    dc_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || dc_enable !== 1'b0) begin bad++;
      $display("FAIL lb_resp_valid got=%b dc_enable=%b exp=1/0", resp_valid, dc_enable); end
    total++; if (resp_data !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++;
      $display("FAIL lb_resp_data got=%h exp=ffffffffffffff80", resp_data); end
    total++; if (resp_tag !== 5'd5 || resp_misaligned !== 1'b0) begin bad++;
      $display("FAIL lb_tag got=%0d mis=%b exp=5/0", resp_tag, resp_misaligned); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    total++; if (load_count !== 32'd1 || resp_valid !== 1'b0) begin bad++;
      $display("FAIL lb_count got=%0d resp_valid=%b exp=1/0", load_count, resp_valid); end
  endtask

  task automatic test_store_word();
    int errs = 0;
    drive_req(64'h2004, 64'hDEADBEEF, 2'd2, 1'b0, 1'b1, 5'd7);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dc_enable !== 1'b1 || dc_addr !== 64'h2004 || dc_wlen !== 2'd2 ||
          dc_wdata !== 64'hDEADBEEF || dc_wrn !== 1'b1) errs++;
      step();
    end
    total++; if (errs != 0) begin bad++;
      $display("FAIL sw_stable unstable_cycles=%0d exp=0", errs); end
    dc_write_done = 1'b1;
    step();
    dc_write_done = 1'b0;
    total++; if (dc_enable !== 1'b0 || resp_valid !== 1'b1) begin bad++;
      $display("FAIL sw_commit dc_enable=%b resp_valid=%b exp=0/1", dc_enable, resp_valid); end
    total++; if (stall_cycles !== 32'd10) begin bad++;
      $display("FAIL sw_stall got=%0d exp=10", stall_cycles); end
    total++; if (resp_data !== 64'd0 || resp_tag !== 5'd7) begin bad++;
      $display("FAIL sw_resp data=%h tag=%0d exp=0/7", resp_data, resp_tag); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    total++; if (store_count !== 32'd1 || load_count !== 32'd1) begin bad++;
      $display("FAIL sw_count store=%0d load=%0d exp=1/1", store_count, load_count); end
  endtask

  task automatic test_misaligned();
    drive_req(64'h3001, 64'd0, 2'd1, 1'b0, 1'b0, 5'd3);
    step();
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_misaligned !== 1'b1) begin bad++;
      $display("FAIL mis_resp valid=%b mis=%b exp=1/1", resp_valid, resp_misaligned); end
    total++; if (resp_data !== 64'd0 || dc_enable !== 1'b0 || resp_tag !== 5'd3) begin bad++;
      $display("FAIL mis_data data=%h dc_enable=%b tag=%0d exp=0/0/3", resp_data, dc_enable, resp_tag); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    total++; if (load_count !== 32'd1 || store_count !== 32'd1 || dc_enable !== 1'b0) begin bad++;
      $display("FAIL mis_count load=%0d store=%0d dc_enable=%b exp=1/1/0", load_count, store_count, dc_enable); end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    drive_req(64'h40, 64'd0, 2'd3, 1'b0, 1'b0, 5'd1);
    step();
    total++; if (dc_enable !== 1'b1 || dc_addr !== 64'h40 || req_ready !== 1'b0) begin bad++;
      $display("FAIL b2b_first dc_enable=%b addr=%h req_ready=%b exp=1/40/0", dc_enable, dc_addr, req_ready); end
    drive_req(64'h48, 64'd0, 2'd2, 1'b0, 1'b0, 5'd2);
    dc_rdata = 64'h1122_3344_5566_7788;
    dc_valid = 1'b1;
    step();
    dc_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_data !== 64'h1122_3344_5566_7788 || resp_tag !== 5'd1) begin bad++;
      $display("FAIL b2b_resp1 valid=%b data=%h tag=%0d exp=1/1122334455667788/1", resp_valid, resp_data, resp_tag); end
    total++; if (dc_enable !== 1'b0 || req_ready !== 1'b1) begin bad++;
      $display("FAIL b2b_gap dc_enable=%b req_ready=%b exp=0/1", dc_enable, req_ready); end
    step();
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    total++; if (dc_enable !== 1'b1 || dc_addr !== 64'h48 || load_count !== 32'd2) begin bad++;
      $display("FAIL b2b_second dc_enable=%b addr=%h loads=%0d exp=1/48/2", dc_enable, dc_addr, load_count); end
    dc_rdata = 64'hAABB_CCDD_8000_0001;
    dc_valid = 1'b1;
    step();
    dc_valid = 1'b0;
    total++; if (resp_data !== 64'hFFFF_FFFF_8000_0001 || resp_tag !== 5'd2) begin bad++;
      $display("FAIL b2b_resp2 data=%h tag=%0d exp=ffffffff80000001/2", resp_data, resp_tag); end
  endtask

  task automatic test_resp_hold();
    int errs = 0;
    drive_req(64'h60, 64'd0, 2'd0, 1'b1, 1'b0, 5'd9);
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_8000_0001 || resp_tag !== 5'd2 ||
          req_ready !== 1'b0 || dc_enable !== 1'b0) errs++;
      step();
    end
    total++; if (errs != 0) begin bad++;
      $display("FAIL hold_stable bad_cycles=%0d exp=0", errs); end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0 || load_count !== 32'd3 || req_ready !== 1'b1) begin bad++;
      $display("FAIL hold_release valid=%b loads=%0d req_ready=%b exp=0/3/1", resp_valid, load_count, req_ready); end
  endtask

  task automatic test_reset_in_access();
    int seen = 0;
    drive_req(64'h50, 64'd0, 2'd3, 1'b0, 1'b0, 5'd4);
    step();
    req_valid = 1'b0;
    total++; if (dc_enable !== 1'b1) begin bad++; $display("FAIL rst_pre dc_enable=%b exp=1", dc_enable); end
    reset = 1'b1;
    #1;
    total++; if (dc_enable !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++;
      $display("FAIL rst_async dc_enable=%b req_ready=%b resp_valid=%b exp=0/1/0", dc_enable, req_ready, resp_valid); end
    total++; if ({load_count, store_count, stall_cycles} !== '0) begin bad++;
      $display("FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", load_count, store_count, stall_cycles); end
    #1 reset = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_valid !== 1'b0 || dc_enable !== 1'b0) seen++;
    end
    resp_ready = 1'b0;
    total++; if (seen != 0) begin bad++; $display("FAIL rst_no_resp activity_cycles=%0d exp=0", seen); end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    req_unsigned = 1'b0; req_store = 1'b0; req_tag = '0;
    resp_ready = 1'b0; dc_rdata = '0; dc_valid = 1'b0; dc_write_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_load_byte();
    test_store_word();
    test_misaligned();
    test_back_to_back();
    test_resp_hold();
    test_reset_in_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
